// File: rtl/ex_wb_hazard_controller.sv
// ----------------------------------------------------------------------------
// ex_wb_hazard_controller
//
// Hazard unit for a two-stage EX -> WB pipeline with a multi-cycle BNN
// popcount in EX and a load in W that waits on external memory.
//
// Stall/flush behaviour is a Mealy function of the current state and the
// current inputs. Pipeline registers must see a stall in the same cycle that
// the hazard appears, so these outputs are decoded combinationally from the
// registered state. They are forced low while reset is asserted.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   A1_E, A2_E          source register addresses of the instruction in EX
//   A3_W, A4_W          primary / secondary destinations in the EX/WB register
//   RegWriteW           write enable for A3_W
//   Reg2WriteW          write enable for A4_W
//   MemReadW            load in W is waiting on external memory
//   mem_ready           external read data valid this cycle
//   PopStartE           multi-cycle popcount in EX
//   BranchTakenE        branch/jump in EX resolved taken
//   StallF/E/W          hold fetch / EX input register / EX/WB register
//   FlushE/W            load a bubble into EX input / EX/WB register
//   ForwardAE/BE        00 regfile, 01 ALUResultW, 10 length_adjusted_W
//   stall_cycles        saturating count of cycles with StallE=1
//   o_state_dbg         current FSM state (00 RUN, 01 MEM_WAIT, 10 POP)
//
// There is no valid/ready handshake here: mem_ready is a one-cycle
// data-valid strobe sampled only while a load waits in W.
// ----------------------------------------------------------------------------
module ex_wb_hazard_controller #(
   parameter int unsigned POP_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1_E,
   input  logic [4:0]  A2_E,
   input  logic [4:0]  A3_W,
   input  logic [4:0]  A4_W,
   input  logic        RegWriteW,
   input  logic        Reg2WriteW,
   input  logic        MemReadW,
   input  logic        mem_ready,
   input  logic        PopStartE,
   input  logic        BranchTakenE,
   output logic        StallF,
   output logic        StallE,
   output logic        StallW,
   output logic        FlushE,
   output logic        FlushW,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic [31:0] stall_cycles,
   output logic [1:0]  o_state_dbg
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_POP      = 2'd2
   } state_t;

   // The first popcount cycle is spent in RUN and the last one (cnt==0)
   // releases the stall, so the counter covers the POP_CYCLES-2 in between.
   localparam logic [3:0] POP_LOAD = 4'(POP_CYCLES - 2);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [31:0] r_stall_cycles;

   state_t      w_next_state;
   logic [3:0]  w_next_cnt;

   // Next-state and stall/flush decode
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      StallF       = 1'b0;
      StallE       = 1'b0;
      StallW       = 1'b0;
      FlushE       = 1'b0;
      FlushW       = 1'b0;
      if (!reset) begin
         case (r_state)
            ST_RUN: begin
               // A load waiting on memory outranks popcount and branch:
               // the whole pipe must freeze until the data arrives.
               if (MemReadW && !mem_ready) begin
                  StallF       = 1'b1;
                  StallE       = 1'b1;
                  StallW       = 1'b1;
                  w_next_state = ST_MEM_WAIT;
               end else if (PopStartE) begin
                  StallF       = 1'b1;
                  StallE       = 1'b1;
                  FlushW       = 1'b1;
                  w_next_state = ST_POP;
                  w_next_cnt   = POP_LOAD;
               end else if (BranchTakenE) begin
                  FlushE = 1'b1;
               end
            end
            ST_MEM_WAIT: begin
               // Still stalled in the cycle mem_ready arrives; W captures
               // the data on that edge.
               StallF = 1'b1;
               StallE = 1'b1;
               StallW = 1'b1;
               if (mem_ready) begin
                  w_next_state = ST_RUN;
               end
            end
            ST_POP: begin
               if (r_cnt != 4'd0) begin
                  StallF     = 1'b1;
                  StallE     = 1'b1;
                  FlushW     = 1'b1;
                  w_next_cnt = r_cnt - 4'd1;
               end else begin
                  // Final cycle: nothing held, W captures the result.
                  w_next_state = ST_RUN;
               end
            end
            default: begin
               w_next_state = ST_RUN;
               w_next_cnt   = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= ST_RUN;
         r_cnt          <= 4'd0;
         r_stall_cycles <= 32'd0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
         if (StallE && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
         end
      end
   end

   // Forwarding: the primary destination wins over the secondary one;
   // register 0 is never forwarded.
   always_comb begin
      ForwardAE = 2'b00;
      if (RegWriteW && (A3_W != 5'd0) && (A3_W == A1_E)) begin
         ForwardAE = 2'b01;
      end else if (Reg2WriteW && (A4_W != 5'd0) && (A4_W == A1_E)) begin
         ForwardAE = 2'b10;
      end
   end

   always_comb begin
      ForwardBE = 2'b00;
      if (RegWriteW && (A3_W != 5'd0) && (A3_W == A2_E)) begin
         ForwardBE = 2'b01;
      end else if (Reg2WriteW && (A4_W != 5'd0) && (A4_W == A2_E)) begin
         ForwardBE = 2'b10;
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign o_state_dbg  = r_state;

endmodule
